// File: rtl/password_ctrl_if.sv
// Signal bundle between the debounced switch/button front end, the password
// controller, and the LED/7-segment display logic.
interface password_ctrl_if;
    logic [9:0] sw_clean;
    logic       btn_enter;
    logic       btn_clear;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_count;
    logic [1:0] attempts_left;
    logic [2:0] state;

    modport master (
        output sw_clean, btn_enter, btn_clear,
        input  unlocked, error, locked_out, digit_count, attempts_left, state
    );

    modport slave (
        input  sw_clean, btn_enter, btn_clear,
        output unlocked, error, locked_out, digit_count, attempts_left, state
    );
endinterface

// File: rtl/password_ctrl.sv
// Password lock sequencer: collects a 4-digit BCD code, checks it, and drives
// timed unlock/error/lockout indications with a retry limit.
module password_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 50_000_000,
    parameter int unsigned ERR_CYCLES  = 25_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    password_ctrl_if.slave  bus
);
    localparam int unsigned TIMER_W = 32;
    localparam int unsigned BUF_W   = 16;

    localparam logic [2:0] ST_ENTRY   = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam logic [1:0]         TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ERR_LOAD   = TIMER_W'(ERR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCK_CYCLES - 1);

    logic [2:0]         r_state;
    logic [BUF_W-1:0]   r_buf;
    logic [2:0]         r_cnt;
    logic [1:0]         r_att;
    logic [TIMER_W-1:0] r_timer;
    logic               r_enter_q;
    logic               r_clear_q;
    logic               r_unlocked;
    logic               r_error;
    logic               r_locked_out;

    logic [2:0]         w_state_nxt;
    logic [BUF_W-1:0]   w_buf_nxt;
    logic [2:0]         w_cnt_nxt;
    logic [1:0]         w_att_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_enter_press;
    logic               w_clear_press;
    logic [3:0]         w_digit;
    logic               w_timer_done;

    assign w_enter_press = bus.btn_enter & ~r_enter_q;
    assign w_clear_press = bus.btn_clear & ~r_clear_q;
    assign w_digit       = bus.sw_clean[3:0];
    assign w_timer_done  = (r_timer == '0);

    // Next-state logic; clear has priority over enter in ENTRY and OPEN.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_att_nxt   = r_att;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_ENTRY: begin
                if (w_clear_press) begin
                    w_buf_nxt = '0;
                    w_cnt_nxt = 3'd0;
                end else if (w_enter_press && (w_digit <= 4'd9)) begin
                    w_buf_nxt = {r_buf[BUF_W-5:0], w_digit};
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'd3) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_buf_nxt = '0;
                w_cnt_nxt = 3'd0;
                if (r_buf == PASSWORD) begin
                    w_state_nxt = ST_OPEN;
                    w_att_nxt   = TRIES_INIT;
                    w_timer_nxt = OPEN_LOAD;
                end else if (r_att > 2'd1) begin
                    w_state_nxt = ST_FAIL;
                    w_att_nxt   = r_att - 2'd1;
                    w_timer_nxt = ERR_LOAD;
                end else begin
                    w_state_nxt = ST_LOCKOUT;
                    w_att_nxt   = 2'd0;
                    w_timer_nxt = LOCK_LOAD;
                end
            end
            ST_OPEN: begin
                if (w_clear_press || w_timer_done) begin
                    w_state_nxt = ST_ENTRY;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            ST_FAIL: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_ENTRY;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_ENTRY;
                    w_att_nxt   = TRIES_INIT;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
                w_buf_nxt   = '0;
                w_cnt_nxt   = 3'd0;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, datapath and registered indication outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ENTRY;
            r_buf        <= '0;
            r_cnt        <= 3'd0;
            r_att        <= TRIES_INIT;
            r_timer      <= '0;
            r_enter_q    <= 1'b0;
            r_clear_q    <= 1'b0;
            r_unlocked   <= 1'b0;
            r_error      <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_att        <= w_att_nxt;
            r_timer      <= w_timer_nxt;
            r_enter_q    <= bus.btn_enter;
            r_clear_q    <= bus.btn_clear;
            r_unlocked   <= (w_state_nxt == ST_OPEN);
            r_error      <= (w_state_nxt == ST_FAIL);
            r_locked_out <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign bus.unlocked      = r_unlocked;
    assign bus.error         = r_error;
    assign bus.locked_out    = r_locked_out;
    assign bus.digit_count   = r_cnt;
    assign bus.attempts_left = r_att;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_password_ctrl.sv
// Directed bench for password_ctrl: queue-based reference model compared every
// cycle, plus hand-computed expectations for hold lengths and counters.
module tb_password_ctrl;
    localparam int T_OPEN = 8;
    localparam int T_ERR  = 4;
    localparam int T_LOCK = 16;
    localparam int TRIES  = 3;
    localparam logic [15:0] PW = 16'h1234;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    password_ctrl_if ifc ();

    password_ctrl #(
        .PASSWORD    (PW),
        .MAX_TRIES   (TRIES),
        .OPEN_CYCLES (T_OPEN),
        .ERR_CYCLES  (T_ERR),
        .LOCK_CYCLES (T_LOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: mode name, queue of entered digits, remaining hold cycles.
    int        m_mode = 0;   // 0 entry, 1 check, 2 open, 3 fail, 4 lockout
    int        m_att  = TRIES;
    int        m_hold = 0;
    int        m_digits[$];
    bit        m_pe = 0, m_pc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_att = TRIES; m_hold = 0;
                m_digits.delete(); m_pe = 0; m_pc = 0;
            end else begin
                bit ep, cp;
                int code;
                ep = ifc.btn_enter && !m_pe;
                cp = ifc.btn_clear && !m_pc;
                m_pe = ifc.btn_enter;
                m_pc = ifc.btn_clear;
                case (m_mode)
                    0: if (cp) m_digits.delete();
                       else if (ep && int'(ifc.sw_clean[3:0]) < 10) begin
                           m_digits.push_back(int'(ifc.sw_clean[3:0]));
                           if (m_digits.size() == 4) m_mode = 1;
                       end
                    1: begin
                        code = 0;
                        foreach (m_digits[k]) code = code * 16 + m_digits[k];
                        m_digits.delete();
                        if (code == int'(PW)) begin m_mode = 2; m_att = TRIES; m_hold = T_OPEN; end
                        else if (m_att > 1) begin m_mode = 3; m_att--; m_hold = T_ERR; end
                        else begin m_mode = 4; m_att = 0; m_hold = T_LOCK; end
                    end
                    2: if (cp) m_mode = 0;
                       else begin m_hold--; if (m_hold == 0) m_mode = 0; end
                    3: begin m_hold--; if (m_hold == 0) m_mode = 0; end
                    default: begin
                        m_hold--;
                        if (m_hold == 0) begin m_mode = 0; m_att = TRIES; end
                    end
                endcase
            end
        end
    end

    // Cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cycle_state", int'(ifc.state), m_mode);
            check("cycle_outs",
                  int'({ifc.unlocked, ifc.error, ifc.locked_out, ifc.digit_count, ifc.attempts_left}),
                  int'({m_mode == 2, m_mode == 3, m_mode == 4, 3'(m_digits.size()), 2'(m_att)}));
        end
    end

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        ifc.sw_clean  = {6'h2A, d};
        ifc.btn_enter = 1'b1;
        @(negedge clk);
        ifc.btn_enter = 1'b0;
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    // Count cycles a chosen indication is high over a window; optionally toggle enter.
    task automatic measure(input int sel, input int win, input bit poke, output int n);
        n = 0;
        for (int i = 0; i < win; i++) begin
            @(negedge clk);
            case (sel)
                0: n += int'(ifc.unlocked);
                1: n += int'(ifc.error);
                default: n += int'(ifc.locked_out);
            endcase
            if (poke) begin
                ifc.sw_clean  = 10'd1;
                ifc.btn_enter = (i % 2 == 0);
            end
        end
        ifc.btn_enter = 1'b0;
    endtask

    initial begin
        int n, n2;
        ifc.sw_clean  = '0;
        ifc.btn_enter = 1'b0;
        ifc.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(ifc.state), 0);
        check("rst_att", int'(ifc.attempts_left), 3);
        check("rst_ind", int'({ifc.unlocked, ifc.error, ifc.locked_out, ifc.digit_count}), 0);
        rst_n = 1'b1;

        // Correct code
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("ok_check_state", int'(ifc.state), 1);
        check("ok_check_dc", int'(ifc.digit_count), 4);
        measure(0, 12, 1'b0, n);
        check("ok_open_len", n, 8);
        check("ok_state_after", int'(ifc.state), 0);
        check("ok_att", int'(ifc.attempts_left), 3);

        // Wrong then correct
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        measure(1, 8, 1'b0, n);
        check("wrong_err_len", n, 4);
        check("wrong_att", int'(ifc.attempts_left), 2);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        measure(0, 12, 1'b0, n);
        check("retry_open_len", n, 8);
        check("retry_att", int'(ifc.attempts_left), 3);

        // Three wrong codes -> lockout, presses during lockout ignored
        for (int k = 0; k < 3; k++) begin
            enter_code(4'd5, 4'd6, 4'd7, 4'd8);
            if (k < 2) begin
                measure(1, 8, 1'b0, n);
                check("lk_err_len", n, 4);
            end
        end
        measure(2, 10, 1'b1, n);
        check("lk_dc_ignored", int'(ifc.digit_count), 0);
        check("lk_att_zero", int'(ifc.attempts_left), 0);
        measure(2, 12, 1'b0, n2);
        check("lk_len", n + n2, 16);
        check("lk_att_restored", int'(ifc.attempts_left), 3);
        check("lk_state_after", int'(ifc.state), 0);

        // Entry filtering
        @(negedge clk);
        ifc.sw_clean = 10'd1; ifc.btn_enter = 1'b1;
        repeat (20) @(negedge clk);
        ifc.btn_enter = 1'b0;
        @(negedge clk);
        check("hold_one_digit", int'(ifc.digit_count), 1);
        press(4'hA);
        check("bad_digit_ignored", int'(ifc.digit_count), 1);
        press(4'd2);
        check("second_digit", int'(ifc.digit_count), 2);
        @(negedge clk);
        ifc.sw_clean = 10'd3; ifc.btn_enter = 1'b1; ifc.btn_clear = 1'b1;
        @(negedge clk);
        ifc.btn_enter = 1'b0; ifc.btn_clear = 1'b0;
        check("clear_wins", int'(ifc.digit_count), 0);
        @(negedge clk);

        // Early exit from OPEN with clear
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        check("early_open", int'(ifc.unlocked), 1);
        @(negedge clk);
        @(negedge clk);
        ifc.btn_clear = 1'b1;
        @(negedge clk);
        ifc.btn_clear = 1'b0;
        check("early_unlocked_low", int'(ifc.unlocked), 0);
        check("early_state", int'(ifc.state), 0);

        // Reset during lockout and with digits pending
        for (int k = 0; k < 3; k++) begin
            enter_code(4'd9, 4'd9, 4'd9, 4'd9);
            if (k < 2) measure(1, 8, 1'b0, n);
        end
        @(negedge clk); @(negedge clk);
        check("rst_lk_before", int'(ifc.locked_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_lk_ind", int'({ifc.unlocked, ifc.error, ifc.locked_out}), 0);
        check("rst_lk_state", int'(ifc.state), 0);
        check("rst_lk_att", int'(ifc.attempts_left), 3);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd1); press(4'd2);
        check("pend_dc", int'(ifc.digit_count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pend_dc", int'(ifc.digit_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        check("post_rst_unlock", int'(ifc.unlocked), 1);
        check("post_rst_att", int'(ifc.attempts_left), 3);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
